// File: rtl/call_dispatcher.sv
// call_dispatcher
//   Request stage in front of the elevator controller. Latches cabin and hall
//   button presses into per-floor bitmaps and picks the next floor with a LOOK
//   sweep. It issues that floor as a one-cycle `pressed` strobe with `target`
//   and `direction`. It watches the controller's floor, door and motion to
//   detect arrival, clear served calls and hold a door dwell.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   car_call            cabin buttons, one bit per floor
//   hall_up             hall up buttons (top floor bit ignored)
//   hall_down           hall down buttons (floor 0 bit ignored)
//   current_floor       controller's present floor
//   door_state          controller door (OPEN/CLOSE)
//   elevator_direction  controller motion (UP/DOWN/IDLE)
//   target, direction   last issued floor and its direction
//   pressed             one-cycle issue strobe
//   pending             OR of all latched calls per floor
//   busy                high whenever the dispatcher is not idle

package call_dispatcher_pkg;
    typedef logic [3:0] floor_t;
    typedef enum logic {DOOR_CLOSE = 1'b0, DOOR_OPEN = 1'b1} door_t;
    typedef enum logic [1:0] {DIR_IDLE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} direction_t;
endpackage

module call_dispatcher
    import call_dispatcher_pkg::*;
#(
    parameter int          NUM_FLOORS     = 8,
    parameter logic [31:0] DWELL_CYCLES   = 32'd100000000,
    parameter int          ACCEPT_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] car_call,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_down,
    input  floor_t                current_floor,
    input  door_t                 door_state,
    input  direction_t            elevator_direction,
    output floor_t                target,
    output direction_t            direction,
    output logic                  pressed,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE_D, ISSUE_D, WAIT_ACCEPT_D, MOVING_D, DWELL_D} state_t;

    // There is no "up" from the top floor and no "down" from floor 0.
    localparam logic [NUM_FLOORS-1:0] UP_VALID   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DOWN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] car_q, car_d, up_q, up_d, down_q, down_d;
    floor_t                target_q, target_d;
    direction_t            dir_q, dir_d, sweep_q, sweep_d;
    logic [31:0]           to_cnt_q, to_cnt_d, dwell_q, dwell_d;

    logic [NUM_FLOORS-1:0] cur_onehot, above_mask, below_mask;
    logic [NUM_FLOORS-1:0] cand, cand_above, cand_below, clr_mask, press_valid;
    logic                  parked, clear_en, press_here;
    logic                  sel_valid;
    floor_t                sel_floor, lo_above, hi_below;
    direction_t            sel_sweep;

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign cur_onehot[gi] = (current_floor == floor_t'(gi));
            assign above_mask[gi] = (floor_t'(gi) > current_floor);
            assign below_mask[gi] = (floor_t'(gi) < current_floor);
        end
    endgenerate

    assign parked      = (door_state == DOOR_OPEN) && (elevator_direction == DIR_IDLE);
    assign clear_en    = parked && ((state_q == IDLE_D) || (state_q == DWELL_D));
    assign clr_mask    = clear_en ? cur_onehot : '0;
    assign press_valid = car_call | (hall_up & UP_VALID) | (hall_down & DOWN_VALID);
    assign press_here  = |(press_valid & cur_onehot);

    // Clear is applied after the OR so a same-cycle press at a served floor loses.
    assign car_d  = (car_q  | car_call)                & ~clr_mask;
    assign up_d   = (up_q   | (hall_up & UP_VALID))    & ~clr_mask;
    assign down_d = (down_q | (hall_down & DOWN_VALID)) & ~clr_mask;

    // The current floor is never a candidate; those calls are served by the clear.
    assign cand       = (car_q | up_q | down_q) & ~cur_onehot;
    assign cand_above = cand & above_mask;
    assign cand_below = cand & below_mask;

    // LOOK selection: continue the sweep if anything lies ahead, else reverse.
    always_comb begin
        lo_above  = '0;
        hi_below  = '0;
        sel_valid = 1'b0;
        sel_floor = '0;
        sel_sweep = sweep_q;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (cand_above[i]) lo_above = floor_t'(i);
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (cand_below[i]) hi_below = floor_t'(i);
        end
        if (sweep_q == DIR_DOWN) begin
            if (|cand_below) begin
                sel_valid = 1'b1;
                sel_floor = hi_below;
            end else if (|cand_above) begin
                sel_valid = 1'b1;
                sel_floor = lo_above;
                sel_sweep = DIR_UP;
            end
        end else begin
            if (|cand_above) begin
                sel_valid = 1'b1;
                sel_floor = lo_above;
            end else if (|cand_below) begin
                sel_valid = 1'b1;
                sel_floor = hi_below;
                sel_sweep = DIR_DOWN;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        sweep_d  = sweep_q;
        to_cnt_d = to_cnt_q;
        dwell_d  = dwell_q;
        case (state_q)
            IDLE_D: begin
                if (sel_valid) begin
                    target_d = sel_floor;
                    dir_d    = (sel_floor > current_floor) ? DIR_UP : DIR_DOWN;
                    sweep_d  = sel_sweep;
                    state_d  = ISSUE_D;
                end
            end
            ISSUE_D: begin
                to_cnt_d = '0;
                state_d  = WAIT_ACCEPT_D;
            end
            WAIT_ACCEPT_D: begin
                if (elevator_direction != DIR_IDLE) begin
                    state_d = MOVING_D;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                    // Controller never started; drop back and re-issue.
                    if (to_cnt_q + 32'd1 == 32'(ACCEPT_TIMEOUT)) state_d = IDLE_D;
                end
            end
            MOVING_D: begin
                if (parked) begin
                    dwell_d = '0;
                    state_d = DWELL_D;
                end
            end
            DWELL_D: begin
                // A fresh press at this floor keeps the door open a full dwell.
                if (press_here) begin
                    dwell_d = '0;
                end else if (dwell_q == DWELL_CYCLES - 32'd1) begin
                    state_d = IDLE_D;
                end else begin
                    dwell_d = dwell_q + 32'd1;
                end
            end
            default: state_d = IDLE_D;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE_D;
            car_q    <= '0;
            up_q     <= '0;
            down_q   <= '0;
            target_q <= '0;
            dir_q    <= DIR_IDLE;
            sweep_q  <= DIR_UP;
            to_cnt_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            car_q    <= car_d;
            up_q     <= up_d;
            down_q   <= down_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            sweep_q  <= sweep_d;
            to_cnt_q <= to_cnt_d;
            dwell_q  <= dwell_d;
        end
    end

    assign target    = target_q;
    assign direction = dir_q;
    assign pressed   = (state_q == ISSUE_D);
    assign pending   = car_q | up_q | down_q;
    assign busy      = (state_q != IDLE_D);

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed testbench for call_dispatcher with a small behavioural
// elevator controller that moves one floor per cycle.
module tb_call_dispatcher;
    import call_dispatcher_pkg::*;

    localparam int NF = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] car_call, hall_up, hall_down;
    floor_t        current_floor;
    door_t         door_state;
    direction_t    elevator_direction;
    floor_t        target;
    direction_t    direction;
    logic          pressed;
    logic [NF-1:0] pending;
    logic          busy;

    int     total = 0;
    int     bad = 0;
    logic   accept_en;
    floor_t m_tgt;
    int     n;
    logic   seen;

    always #5 clk = ~clk;

    call_dispatcher #(
        .NUM_FLOORS    (NF),
        .DWELL_CYCLES  (32'd4),
        .ACCEPT_TIMEOUT(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .car_call          (car_call),
        .hall_up           (hall_up),
        .hall_down         (hall_down),
        .current_floor     (current_floor),
        .door_state        (door_state),
        .elevator_direction(elevator_direction),
        .target            (target),
        .direction         (direction),
        .pressed           (pressed),
        .pending           (pending),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, obs);
        end
    endtask

    task automatic park(input floor_t f);
        current_floor      = f;
        elevator_direction = DIR_IDLE;
        door_state         = DOOR_OPEN;
    endtask

    // One clock; the controller model steps on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (pressed && accept_en) begin
            m_tgt              = target;
            elevator_direction = (target > current_floor) ? DIR_UP : DIR_DOWN;
            door_state         = DOOR_CLOSE;
        end else if (elevator_direction != DIR_IDLE) begin
            if (current_floor == m_tgt) begin
                elevator_direction = DIR_IDLE;
                door_state         = DOOR_OPEN;
            end else if (m_tgt > current_floor) begin
                current_floor = current_floor + 4'd1;
            end else begin
                current_floor = current_floor - 4'd1;
            end
        end
    endtask

    task automatic wait_pressed(input string tag, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!pressed && cnt < max);
        chk({tag, "_pulse"}, 32'(pressed), 32'd1);
    endtask

    task automatic wait_parked(input string tag, input int max);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (elevator_direction != DIR_IDLE && c < max);
        if (elevator_direction != DIR_IDLE) chk({tag, "_arrive"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (busy && cnt < max);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        car_call  = '0;
        hall_up   = '0;
        hall_down = '0;
        accept_en = 1'b1;
        m_tgt     = '0;
        park(4'd0);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_target", 32'(target), 32'd0);
        chk("rst_dir", 32'(direction), 32'(DIR_IDLE));
        rst_n = 1'b1;
        tick();

        // Single call from floor 0 to floor 5
        car_call = 8'h20;
        tick();
        car_call = '0;
        chk("t1_pending", 32'(pending), 32'h20);
        chk("t1_no_pulse_yet", 32'(pressed), 32'd0);
        tick();
        chk("t1_pressed", 32'(pressed), 32'd1);
        chk("t1_target", 32'(target), 32'd5);
        chk("t1_dir", 32'(direction), 32'(DIR_UP));
        tick();
        chk("t1_one_shot", 32'(pressed), 32'd0);
        chk("t1_target_hold", 32'(target), 32'd5);
        wait_parked("t1", 40);
        wait_idle("t1", 40, n);
        chk("t1_dwell_len", 32'(n), 32'd5);
        chk("t1_cleared", 32'(pending), 32'd0);

        // LOOK order from floor 3, sweeping up
        park(4'd3);
        car_call = 8'h52;
        tick();
        car_call = '0;
        chk("t2_pending", 32'(pending), 32'h52);
        wait_pressed("t2a", 60, n);
        chk("t2a_target", 32'(target), 32'd4);
        chk("t2a_dir", 32'(direction), 32'(DIR_UP));
        wait_pressed("t2b", 60, n);
        chk("t2b_target", 32'(target), 32'd6);
        chk("t2b_dir", 32'(direction), 32'(DIR_UP));
        wait_pressed("t2c", 60, n);
        chk("t2c_target", 32'(target), 32'd1);
        chk("t2c_dir", 32'(direction), 32'(DIR_DOWN));
        wait_parked("t2", 40);
        wait_idle("t2", 40, n);
        chk("t2_cleared", 32'(pending), 32'd0);

        // Call at the parked floor is served by the clear, never issued
        park(4'd2);
        hall_up = 8'h04;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            hall_up = '0;
            if (pressed || pending[2]) seen = 1'b1;
        end
        chk("t3_here_silent", 32'(seen), 32'd0);

        // Press at the served floor during dwell restarts the dwell
        park(4'd0);
        car_call = 8'h04;
        tick();
        car_call = '0;
        wait_pressed("t3", 30, n);
        chk("t3_target", 32'(target), 32'd2);
        wait_parked("t3", 40);
        tick();
        tick();
        car_call = 8'h04;
        tick();
        car_call = '0;
        chk("t3_dwell_clear", 32'(pending), 32'd0);
        wait_idle("t3", 40, n);
        chk("t3_dwell_restart", 32'(n), 32'd4);

        // Controller ignores the strobe: retry after the accept timeout
        accept_en = 1'b0;
        park(4'd0);
        car_call = 8'h08;
        tick();
        car_call = '0;
        wait_pressed("t4a", 30, n);
        chk("t4a_target", 32'(target), 32'd3);
        wait_pressed("t4b", 30, n);
        chk("t4_retry_gap", 32'(n), 32'd6);
        chk("t4b_target", 32'(target), 32'd3);
        chk("t4b_dir", 32'(direction), 32'(DIR_UP));
        accept_en = 1'b1;
        wait_pressed("t4c", 30, n);
        wait_parked("t4", 40);
        wait_idle("t4", 40, n);
        chk("t4_cleared", 32'(pending), 32'd0);

        // Masked hall buttons never latch
        hall_up   = 8'h80;
        hall_down = 8'h01;
        repeat (3) tick();
        hall_up   = '0;
        hall_down = '0;
        chk("t5_pending", 32'(pending), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pressed) seen = 1'b1;
        end
        chk("t5_no_issue", 32'(seen), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);

        // Asynchronous reset while moving with calls latched
        park(4'd0);
        car_call = 8'h28;
        tick();
        car_call = '0;
        wait_pressed("t6", 30, n);
        chk("t6_target", 32'(target), 32'd3);
        repeat (3) tick();
        chk("t6_moving_busy", 32'(busy), 32'd1);
        chk("t6_moving_pending", 32'(pending), 32'h28);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_target", 32'(target), 32'd0);
        chk("t6_rst_dir", 32'(direction), 32'(DIR_IDLE));
        chk("t6_rst_pressed", 32'(pressed), 32'd0);
        park(4'd2);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pressed) seen = 1'b1;
        end
        chk("t6_quiet_after_rst", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
